// File: rtl/idu_pkg.sv
// Shared decode definitions: opcode map, one-hot type/pipe encodings and the
// per-lane control record stored in the decode queue.
package idu_pkg;

  localparam logic [6:0] OpRAlu64   = 7'b0110011;
  localparam logic [6:0] OpRAlu32   = 7'b0111011;
  localparam logic [6:0] OpIAlu64   = 7'b0010011;
  localparam logic [6:0] OpIAlu32   = 7'b0011011;
  localparam logic [6:0] OpIMemLoad = 7'b0000011;
  localparam logic [6:0] OpIEnv     = 7'b1110011;
  localparam logic [6:0] OpIJalr    = 7'b1100111;
  localparam logic [6:0] OpSMemStr  = 7'b0100011;
  localparam logic [6:0] OpBBranch  = 7'b1100011;
  localparam logic [6:0] OpUAuipc   = 7'b0010111;
  localparam logic [6:0] OpULui     = 7'b0110111;
  localparam logic [6:0] OpJJal     = 7'b1101111;

  // One-hot {R,I,S,B,U,J}
  localparam logic [5:0] TypeR = 6'b100000;
  localparam logic [5:0] TypeI = 6'b010000;
  localparam logic [5:0] TypeS = 6'b001000;
  localparam logic [5:0] TypeB = 6'b000100;
  localparam logic [5:0] TypeU = 6'b000010;
  localparam logic [5:0] TypeJ = 6'b000001;

  // One-hot {alu,mxu,bju,lsu,cp0}
  localparam logic [4:0] PipeAlu = 5'b10000;
  localparam logic [4:0] PipeMxu = 5'b01000;
  localparam logic [4:0] PipeBju = 5'b00100;
  localparam logic [4:0] PipeLsu = 5'b00010;
  localparam logic [4:0] PipeCp0 = 5'b00001;

  // XLEN-wide pc/imm are kept outside the record so it stays width-independent
  typedef struct packed {
    logic       lane_vld;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       src1_vld;
    logic       src2_vld;
    logic       dst_vld;
    logic       imm_vld;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [4:0] dst;
    logic [5:0] itype;
    logic [4:0] pipe;
    logic       ras;
    logic       illegal;
  } lane_ctl_t;

  localparam int unsigned LaneCtlW = $bits(lane_ctl_t);

endpackage

// File: rtl/idu_id_lane_dec.sv
// Combinational single-lane RV64 decoder; an invalid lane decodes to all zeros.
module idu_id_lane_dec
  import idu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_vld,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output lane_ctl_t       o_ctl,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm
);

  logic [6:0]      w_op;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic [5:0]      w_type;
  logic [4:0]      w_pipe;
  logic            w_ras, w_ill, w_has_rd, w_s1v, w_s2v, w_iv;

  assign w_op    = i_inst[6:0];
  assign w_rd    = i_inst[11:7];
  assign w_imm_i = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                    i_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                    i_inst[30:21], 1'b0};

  always_comb begin
    w_type   = '0;
    w_pipe   = '0;
    w_ras    = 1'b0;
    w_ill    = 1'b0;
    w_has_rd = 1'b0;
    w_s1v    = 1'b0;
    w_s2v    = 1'b0;
    w_iv     = 1'b0;
    w_imm    = '0;
    case (w_op)
      OpRAlu64, OpRAlu32: begin
        w_type = TypeR; w_s1v = 1'b1; w_s2v = 1'b1; w_has_rd = 1'b1;
        w_pipe = i_inst[25] ? PipeMxu : PipeAlu;
      end
      OpIAlu64, OpIAlu32, OpIMemLoad, OpIEnv, OpIJalr: begin
        w_type = TypeI; w_s1v = 1'b1; w_iv = 1'b1; w_imm = w_imm_i; w_has_rd = 1'b1;
        w_ras  = (w_op == OpIJalr);
        w_pipe = (w_op == OpIMemLoad) ? PipeLsu :
                 (w_op == OpIEnv)     ? PipeCp0 :
                 (w_op == OpIJalr)    ? PipeBju : PipeAlu;
      end
      OpSMemStr: begin
        w_type = TypeS; w_s1v = 1'b1; w_s2v = 1'b1; w_iv = 1'b1; w_imm = w_imm_s;
        w_pipe = PipeLsu;
      end
      OpBBranch: begin
        w_type = TypeB; w_s1v = 1'b1; w_s2v = 1'b1; w_iv = 1'b1; w_imm = w_imm_b;
        w_pipe = PipeBju;
      end
      OpUAuipc, OpULui: begin
        w_type = TypeU; w_iv = 1'b1; w_imm = w_imm_u; w_has_rd = 1'b1;
        w_pipe = (w_op == OpULui) ? PipeAlu : PipeBju;
      end
      OpJJal: begin
        w_type = TypeJ; w_iv = 1'b1; w_imm = w_imm_j; w_has_rd = 1'b1;
        w_pipe = PipeBju; w_ras = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    o_ctl = '0;
    o_pc  = '0;
    o_imm = '0;
    if (i_vld) begin
      o_ctl.lane_vld = 1'b1;
      o_ctl.opcode   = w_op;
      o_ctl.funct7   = i_inst[31:25];
      o_ctl.funct3   = i_inst[14:12];
      o_ctl.src1_vld = w_s1v;
      o_ctl.src2_vld = w_s2v;
      o_ctl.dst_vld  = w_has_rd & (w_rd != 5'd0);
      o_ctl.imm_vld  = w_iv;
      o_ctl.src1     = w_s1v ? i_inst[19:15] : 5'd0;
      o_ctl.src2     = w_s2v ? i_inst[24:20] : 5'd0;
      o_ctl.dst      = (w_has_rd & (w_rd != 5'd0)) ? w_rd : 5'd0;
      o_ctl.itype    = w_type;
      o_ctl.pipe     = w_pipe;
      o_ctl.ras      = w_ras;
      o_ctl.illegal  = w_ill;
      o_pc           = i_pc;
      o_imm          = w_imm;
    end
  end

endmodule

// File: rtl/idu_id_wide.sv
// N-lane decode stage: per-lane decoders feed a 2-entry skid queue so rename
// backpressure never combinationally reaches the fetch handshake.
module idu_id_wide
  import idu_pkg::*;
#(
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned QDEPTH       = 2
) (
  input  logic                         clk,
  input  logic                         rst_clk,
  input  logic                         rtu_global_flush,
  input  logic                         ifu_idu_id_vld,
  output logic                         ifu_idu_id_rdy,
  input  logic [DECODE_WIDTH-1:0]      ifu_idu_id_inst_vld,
  input  logic [DECODE_WIDTH*XLEN-1:0] ifu_idu_id_inst_pc,
  input  logic [DECODE_WIDTH*32-1:0]   ifu_idu_id_inst,
  output logic                         decode_vld,
  input  logic                         decode_rdy,
  output logic [DECODE_WIDTH-1:0]      decode_lane_vld,
  output logic [DECODE_WIDTH*7-1:0]    decode_opcode,
  output logic [DECODE_WIDTH*7-1:0]    decode_funct7,
  output logic [DECODE_WIDTH*3-1:0]    decode_funct3,
  output logic [DECODE_WIDTH*XLEN-1:0] decode_pc,
  output logic [DECODE_WIDTH-1:0]      decode_src1_vld,
  output logic [DECODE_WIDTH-1:0]      decode_src2_vld,
  output logic [DECODE_WIDTH-1:0]      decode_dst_vld,
  output logic [DECODE_WIDTH-1:0]      decode_imm_vld,
  output logic [DECODE_WIDTH*5-1:0]    decode_src1,
  output logic [DECODE_WIDTH*5-1:0]    decode_src2,
  output logic [DECODE_WIDTH*5-1:0]    decode_dst,
  output logic [DECODE_WIDTH*XLEN-1:0] decode_imm,
  output logic [DECODE_WIDTH*6-1:0]    decode_type,
  output logic [DECODE_WIDTH*5-1:0]    decode_pipe,
  output logic [DECODE_WIDTH-1:0]      decode_ras,
  output logic [DECODE_WIDTH-1:0]      decode_illegal,
  output logic [DECODE_WIDTH-1:0]      iid_req,
  output logic [DECODE_WIDTH-1:0]      preg_req
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  lane_ctl_t       w_ctl [DECODE_WIDTH];
  logic [XLEN-1:0] w_pc  [DECODE_WIDTH];
  logic [XLEN-1:0] w_imm [DECODE_WIDTH];

  lane_ctl_t       r_ctl [QDEPTH][DECODE_WIDTH];
  logic [XLEN-1:0] r_pc  [QDEPTH][DECODE_WIDTH];
  logic [XLEN-1:0] r_imm [QDEPTH][DECODE_WIDTH];
  logic [CntW-1:0] r_cnt;
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic            w_push, w_pop;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_dec
    idu_id_lane_dec #(.XLEN(XLEN)) u_dec (
      .i_vld  (ifu_idu_id_inst_vld[g]),
      .i_pc   (ifu_idu_id_inst_pc[g*XLEN +: XLEN]),
      .i_inst (ifu_idu_id_inst[g*32 +: 32]),
      .o_ctl  (w_ctl[g]),
      .o_pc   (w_pc[g]),
      .o_imm  (w_imm[g])
    );
  end

  assign ifu_idu_id_rdy = (r_cnt != CntW'(QDEPTH));
  assign decode_vld     = (r_cnt != '0);
  // Bundles with no valid lane are accepted but never enqueued
  assign w_push = ifu_idu_id_vld & ifu_idu_id_rdy & (|ifu_idu_id_inst_vld);
  assign w_pop  = decode_vld & decode_rdy;

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk || rtu_global_flush) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      for (int q = 0; q < QDEPTH; q++) begin
        for (int l = 0; l < DECODE_WIDTH; l++) begin
          r_ctl[q][l] <= '0;
          r_pc[q][l]  <= '0;
          r_imm[q][l] <= '0;
        end
      end
    end else begin
      if (w_push) begin
        for (int l = 0; l < DECODE_WIDTH; l++) begin
          r_ctl[r_wptr][l] <= w_ctl[l];
          r_pc[r_wptr][l]  <= w_pc[l];
          r_imm[r_wptr][l] <= w_imm[l];
        end
        r_wptr <= (r_wptr == PtrW'(QDEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(QDEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
    end
  end

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_out
    lane_ctl_t w_head;
    assign w_head = decode_vld ? r_ctl[r_rptr][g] : '0;
    assign decode_pc[g*XLEN +: XLEN]  = decode_vld ? r_pc[r_rptr][g] : '0;
    assign decode_imm[g*XLEN +: XLEN] = decode_vld ? r_imm[r_rptr][g] : '0;
    assign decode_lane_vld[g]    = w_head.lane_vld;
    assign decode_opcode[g*7 +: 7] = w_head.opcode;
    assign decode_funct7[g*7 +: 7] = w_head.funct7;
    assign decode_funct3[g*3 +: 3] = w_head.funct3;
    assign decode_src1_vld[g]    = w_head.src1_vld;
    assign decode_src2_vld[g]    = w_head.src2_vld;
    assign decode_dst_vld[g]     = w_head.dst_vld;
    assign decode_imm_vld[g]     = w_head.imm_vld;
    assign decode_src1[g*5 +: 5] = w_head.src1;
    assign decode_src2[g*5 +: 5] = w_head.src2;
    assign decode_dst[g*5 +: 5]  = w_head.dst;
    assign decode_type[g*6 +: 6] = w_head.itype;
    assign decode_pipe[g*5 +: 5] = w_head.pipe;
    assign decode_ras[g]         = w_head.ras;
    assign decode_illegal[g]     = w_head.illegal;
    assign iid_req[g]            = w_head.lane_vld;
    assign preg_req[g]           = w_head.lane_vld & w_head.dst_vld;
  end

endmodule

// File: doc/idu_id_wide.md
Name: idu_id_wide

Overview:
Parametrised N-lane instruction decode stage between IFU fetch and IDU rename. Per cycle it accepts one bundle of up to DECODE_WIDTH instructions through a valid/ready handshake and decodes every lane into opcode/funct/regs/sign-extended immediate/type/pipe/RAS fields. The decoded bundle is held in a 2-entry skid queue so downstream backpressure never combinationally reaches IFU. Compared with the single-lane decoder, it adds illegal-opcode flagging, a uniform rd==x0 destination suppression rule, and a flush that clears all fields.

Parameters:
DECODE_WIDTH, 2, number of decode lanes (1..4)
XLEN, 64, PC/immediate width
QDEPTH, 2, skid-queue entries (fixed at 2; kept parametric for the pointer width only)

Ports:
clk  in  1  core clock
rst_clk  in  1  asynchronous reset, active-high
rtu_global_flush  in  1  pipeline flush
ifu_idu_id_vld  in  1  bundle valid
ifu_idu_id_rdy  out  1  queue can accept a bundle
ifu_idu_id_inst_vld  in  W  per-lane valid
ifu_idu_id_inst_pc  in  W*XLEN  per-lane PC
ifu_idu_id_inst  in  W*32  per-lane instruction
decode_vld  out  1  head bundle valid
decode_rdy  in  1  rename accepts head bundle
decode_lane_vld  out  W  per-lane valid of head
decode_opcode/funct7/funct3  out  W*7/W*7/W*3  raw fields
decode_pc  out  W*XLEN  lane PC
decode_src1_vld, decode_src2_vld, decode_dst_vld, decode_imm_vld  out  W each
decode_src1, decode_src2, decode_dst  out  W*5 each
decode_imm  out  W*XLEN  sign-extended immediate
decode_type  out  W*6  one-hot {R,I,S,B,U,J}
decode_pipe  out  W*5  one-hot {alu,mxu,bju,lsu,cp0}
decode_ras  out  W  JAL/JALR
decode_illegal  out  W  unrecognised opcode
iid_req  out  W  decode_vld & decode_lane_vld
preg_req  out  W  decode_vld & decode_lane_vld & decode_dst_vld

Behaviour:
- Reset (rst_clk=1, async): queue count=0, pointers=0, all storage zeroed; decode_vld=0, every decode_* output 0, ifu_idu_id_rdy=1.
- ifu_idu_id_rdy = (count != 2); driven from registered state only.
- push = ifu_idu_id_vld & ifu_idu_id_rdy & |ifu_idu_id_inst_vld; an accepted bundle with all lane valids 0 is consumed and dropped.
- pop = decode_vld & decode_rdy; decode_vld = (count != 0); outputs come from the head entry.
- Latency: a bundle pushed in cycle t is visible on decode_* in t+1 when the queue was empty.
- count: push only +1, pop only -1, push&pop unchanged; push while full is impossible (rdy=0). Pointers wrap modulo 2.
- Order preserved; decoded fields are latched at push time.
- Flush: in the cycle after rtu_global_flush=1, count=0, decode_vld=0, and all stored fields are 0. Any push in the flush cycle is discarded. Flush has priority over push/pop.
- Lane decode (combinational, before queue), opcodes: R_ALU64 0110011, R_ALU32 0111011, I_ALU64 0010011, I_ALU32 0011011, I_MEMLOAD 0000011, I_ENV 1110011, I_JALR 1100111, S_MEMSTORE 0100011, B_BRANCH 1100011, U_AUIPC 0010111, U_LUI 0110111, J_JAL 1101111.
- Source/immediate valid by type: R src1,src2; I src1+imm; S/B src1,src2+imm; U/J imm.
- Unused src/imm fields are forced to 0.
- dst_vld = format has rd (R,I,U,J) & rd != 0; decode_dst = 0 when dst_vld=0.
- Immediates: I/S 12-bit, B 13-bit, U {inst[31:12],12'b0}, J 21-bit, all sign-extended to XLEN.
- Pipe: alu = R&!f7[0] | I_ALU* | LUI; mxu = R&f7[0]; bju = JALR|BRANCH|JAL|AUIPC; lsu = LOAD|STORE; cp0 = ENV. ras = JAL|JALR.
- Illegal lane (unknown opcode): illegal=1, type/pipe/ras/all *_vld = 0, imm=0. opcode/funct/pc are still latched.
- Invalid lane: every field 0, including lane_vld.

Decomposition:
- Shared package idu_pkg: opcode constants; the type and pipe one-hot encodings; a decoded-lane record layout with field widths and offsets.
- Sub-module idu_id_lane_dec: purely combinational single-lane decoder, instantiated DECODE_WIDTH times.
- The queue and handshake live in the top module.

Test Plan:
- Reset: assert rst_clk mid-operation with count=2 -> decode_vld=0, ifu_idu_id_rdy=1, all outputs 0 immediately.
- Dual lane: lane0 0x00500093, lane1 0x002081B3 -> next cycle lane0 type 010000, pipe 10000, dst 1, imm 5, src1 0; lane1 type 100000, src1 1, src2 2, dst 3, imm_vld 0.
- Backpressure: decode_rdy=0, push bundles A, B, C -> A and B accepted, rdy=0 after B, C held; decode_rdy=1 -> A then B output, C accepted once count<2.
- Flush with count=2 plus simultaneous push -> next cycle decode_vld=0, rdy=1, all fields 0, pushed bundle never appears.
- JAL rd=x0 0x0000006F -> dst_vld 0, ras 1, pipe 00100. BEQ 0xFE000EE3 -> imm 0xFFFFFFFFFFFFFFFC, src1_vld 1, src2_vld 1. MUL 0x022081B3 -> pipe 01000.
- Illegal 0x0000000F on lane1 with lane0 valid ADDI -> lane1 illegal=1, type 0, pipe 0, lane_vld 1. iid_req=11; preg_req=01 when ADDI rd!=0.
